bayer_window_gen: RTL and testbench
===================================

Name: bayer_window_gen

Overview:
- Upstream neighbour of the Bayer-phase RGGB mux.
- Accepts a raster-order stream of white-balanced 8-bit Bayer pixels, one per cycle when valid.
- Buffers one previous image line and emits every 2x2 neighbourhood as four pixels, plus row/col phase bits in exactly the encoding the RGGB mux consumes.
- Also flags window validity and end of frame.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=2).
- IMG_HEIGHT, 480, lines per frame (>=2).
- PIX_W, 8, bits per pixel.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  reset.
- clear  input  1  synchronous frame restart; counters to 0, line buffer contents don't-care.
- pix_in  input  PIX_W  white-balanced pixel, raster order.
- pix_valid  input  1  pix_in accepted this cycle.
- wb_1  output  PIX_W  window pixel (r-1, c-1).
- wb_2  output  PIX_W  window pixel (r-1, c).
- wb_3  output  PIX_W  window pixel (r, c-1).
- wb_4  output  PIX_W  window pixel (r, c).
- row  output  1  r[0] of the window's bottom-right coordinate.
- col  output  1  ~c[0] of the window's bottom-right coordinate.
- win_valid  output  1  one-cycle strobe: outputs hold a new window.
- frame_done  output  1  one-cycle strobe: last pixel of frame processed.

Behaviour:
- Interface: one clock, clk; reset n_rst is asynchronous, active-low.
  - Reset values: all outputs 0; row and col counters 0; prev-pixel registers 0.
- Coordinates: (r, c) is the position of the accepted pixel.
  - c counts 0..IMG_WIDTH-1 and wraps to 0 with r+1.
  - r counts 0..IMG_HEIGHT-1 and wraps to 0 after the last pixel.
  - Counters advance only on cycles with pix_valid=1. Idle cycles change no state and deassert the strobes.
- Line buffer: IMG_WIDTH x PIX_W storage, inferred RAM or register array.
  - On accept at column c: read entry c, which holds (r-1, c), then overwrite entry c with pix_in in the same cycle (read-before-write).
- Previous-column registers: cur_prev holds (r, c-1); top_prev holds (r-1, c-1). Both update on every accept.
- Window emission, registered, latency 1 cycle after the accepting edge:
  - If r>=1 and c>=1, load wb_1=top_prev, wb_2=linebuf[c], wb_3=cur_prev, wb_4=pix_in, row=r[0], col=~c[0], and pulse win_valid.
  - Otherwise win_valid=0 and wb_*/row/col hold their previous values.
  - Windows never span a line wrap (c=0 never emits) and never use row 0 as the bottom row.
- Phase encoding, for an RGGB sensor with R at (even, even):
  - top-left at (even, even): row=1, col=0.
  - top-left at (even, odd): row=1, col=1.
  - top-left at (odd, even): row=0, col=0.
  - top-left at (odd, odd): row=0, col=1.
- Window count: (IMG_WIDTH-1)*(IMG_HEIGHT-1) windows per frame.
- frame_done:
  - Pulses 1 cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with the last win_valid.
  - Counters wrap; the next frame's row 0 overwrites the buffer and emits nothing.
- clear:
  - clear=1 takes priority over pix_valid in the same cycle: the pixel is dropped, counters go to 0, and win_valid and frame_done are 0 next cycle.
- Reset mid-frame: same effect as clear, applied immediately and asynchronously. Line buffer contents are don't-care afterwards.
- No backpressure: the downstream is combinational/pipelined and always accepts.

Test Plan:
- Params W=4, H=4; stream pixel value 16*r+c with pix_valid held high.
  - First win_valid comes 1 cycle after accept of (1,1) with wb_1..4 = 0x00, 0x01, 0x10, 0x11, row=1, col=0.
  - Next window: 0x01, 0x02, 0x11, 0x12, row=1, col=1.
- Same stream, window at (2,1) -> wb = 0x10, 0x11, 0x20, 0x21, row=0, col=0.
  - Window at (2,2) -> wb = 0x11, 0x12, 0x21, 0x22, row=0, col=1.
  - No win_valid after accepting any c=0 pixel.
- Full frame with random 1-3 cycle gaps in pix_valid:
  - Exactly 9 win_valid pulses, with identical window contents to the gapless run.
  - frame_done pulses once, together with window 0x22, 0x23, 0x32, 0x33.
- Two back-to-back frames, second frame value 0x80+16*r+c:
  - No window in second-frame row 0.
  - First second-frame window = 0x80, 0x81, 0x90, 0x91.
- Assert n_rst low after accepting (2,2), then restart the stream:
  - Outputs 0 during reset.
  - First post-reset window appears only after accepting new (1,1), with correct new-frame values.
- clear=1 together with pix_valid=1 at (1,3):
  - Pixel dropped, no win_valid.
  - Restarted frame behaves exactly as a fresh frame.

Source files
------------

// File: rtl/bayer_window_gen_if.sv
// Bayer window generator bus: raster pixel stream in, 2x2 window plus phase out.
// The window generator takes the slave side; the pixel source / window sink takes the master side.
interface bayer_window_gen_if #(
   parameter int PIX_W = 8
);
   logic             clear;
   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
   logic [PIX_W-1:0] wb_1;
   logic [PIX_W-1:0] wb_2;
   logic [PIX_W-1:0] wb_3;
   logic [PIX_W-1:0] wb_4;
   logic             row;
   logic             col;
   logic             win_valid;
   logic             frame_done;

   modport slave (
      input  clear, pix_in, pix_valid,
      output wb_1, wb_2, wb_3, wb_4, row, col, win_valid, frame_done
   );

   modport master (
      output clear, pix_in, pix_valid,
      input  wb_1, wb_2, wb_3, wb_4, row, col, win_valid, frame_done
   );
endinterface

// File: rtl/bayer_window_gen.sv
// Bayer 2x2 window generator.
// Keeps one previous image line plus the previous pixel of both the current and the
// previous line, and emits every 2x2 neighbourhood whose bottom-right pixel was just
// accepted. Phase bits (row, col) are encoded for the downstream RGGB mux.
module bayer_window_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_W      = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   bayer_window_gen_if.slave    bus
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]    colCnt_q, colCnt_d;
   logic [RW-1:0]    rowCnt_q, rowCnt_d;
   logic [PIX_W-1:0] curPrev_q, curPrev_d;
   logic [PIX_W-1:0] topPrev_q, topPrev_d;
   logic [PIX_W-1:0] wb1_q, wb1_d;
   logic [PIX_W-1:0] wb2_q, wb2_d;
   logic [PIX_W-1:0] wb3_q, wb3_d;
   logic [PIX_W-1:0] wb4_q, wb4_d;
   logic             row_q, row_d;
   logic             col_q, col_d;
   logic             winValid_q, winValid_d;
   logic             frameDone_q, frameDone_d;

   logic [PIX_W-1:0] lineBuf [IMG_WIDTH];
   logic [PIX_W-1:0] abovePix;
   logic             accept;

   // A pixel is taken only when valid and no frame restart is requested in the same cycle.
   assign accept   = bus.pix_valid & ~bus.clear;
   // Entry c still holds pixel (r-1, c) until it is overwritten at the accepting edge.
   assign abovePix = lineBuf[colCnt_q];

   // Line buffer: read-before-write, entry c is replaced by the current pixel on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         lineBuf[colCnt_q] <= bus.pix_in;
      end
   end

   // Next-state: coordinate counters, previous-column registers and window outputs.
   always_comb begin
      colCnt_d    = colCnt_q;
      rowCnt_d    = rowCnt_q;
      curPrev_d   = curPrev_q;
      topPrev_d   = topPrev_q;
      wb1_d       = wb1_q;
      wb2_d       = wb2_q;
      wb3_d       = wb3_q;
      wb4_d       = wb4_q;
      row_d       = row_q;
      col_d       = col_q;
      winValid_d  = 1'b0;
      frameDone_d = 1'b0;

      if (bus.clear) begin
         colCnt_d = '0;
         rowCnt_d = '0;
      end else if (bus.pix_valid) begin
         curPrev_d = bus.pix_in;
         topPrev_d = abovePix;

         if ((rowCnt_q != '0) && (colCnt_q != '0)) begin
            wb1_d      = topPrev_q;
            wb2_d      = abovePix;
            wb3_d      = curPrev_q;
            wb4_d      = bus.pix_in;
            row_d      = rowCnt_q[0];
            col_d      = ~colCnt_q[0];
            winValid_d = 1'b1;
         end

         frameDone_d = (rowCnt_q == ROW_LAST) && (colCnt_q == COL_LAST);

         if (colCnt_q == COL_LAST) begin
            colCnt_d = '0;
            rowCnt_d = (rowCnt_q == ROW_LAST) ? '0 : rowCnt_q + 1'b1;
         end else begin
            colCnt_d = colCnt_q + 1'b1;
         end
      end
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         colCnt_q    <= '0;
         rowCnt_q    <= '0;
         curPrev_q   <= '0;
         topPrev_q   <= '0;
         wb1_q       <= '0;
         wb2_q       <= '0;
         wb3_q       <= '0;
         wb4_q       <= '0;
         row_q       <= 1'b0;
         col_q       <= 1'b0;
         winValid_q  <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         colCnt_q    <= colCnt_d;
         rowCnt_q    <= rowCnt_d;
         curPrev_q   <= curPrev_d;
         topPrev_q   <= topPrev_d;
         wb1_q       <= wb1_d;
         wb2_q       <= wb2_d;
         wb3_q       <= wb3_d;
         wb4_q       <= wb4_d;
         row_q       <= row_d;
         col_q       <= col_d;
         winValid_q  <= winValid_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign bus.wb_1       = wb1_q;
   assign bus.wb_2       = wb2_q;
   assign bus.wb_3       = wb3_q;
   assign bus.wb_4       = wb4_q;
   assign bus.row        = row_q;
   assign bus.col        = col_q;
   assign bus.win_valid  = winValid_q;
   assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_bayer_window_gen.sv
// Testbench for the Bayer 2x2 window generator on a 4x4 image.
// The reference keeps the whole current frame in a 2D array and derives each expected
// window, its phase and the frame-done strobe from pixel coordinates.
module tb_bayer_window_gen;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 8;

   logic clk = 1'b0;
   logic n_rst = 1'b0;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   bayer_window_gen_if #(.PIX_W(PW)) bus ();

   bayer_window_gen #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .PIX_W      (PW)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int nAsserts = 0;
   int nFail    = 0;

   // Reference frame model
   int          mr = 0;
   int          mc = 0;
   logic [7:0]  img [H][W];
   logic [7:0]  e1 = '0, e2 = '0, e3 = '0, e4 = '0;
   logic        eRow = 1'b0, eCol = 1'b0, eValid = 1'b0, eDone = 1'b0;

   // Per-run tallies of observed windows
   int          winCount  = 0;
   int          doneCount = 0;
   logic [31:0] firstWin  = '0;
   logic [31:0] doneWin   = '0;
   bit          haveFirst = 0;
   logic [31:0] runWins [$];
   logic [31:0] refWins [$];

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compares every output against the model and records observed windows.
   task automatic checkOutput();
      logic [31:0] win;
      checkVal("win_valid",  32'(bus.win_valid),  32'(eValid));
      checkVal("frame_done", 32'(bus.frame_done), 32'(eDone));
      checkVal("wb_1", 32'(bus.wb_1), 32'(e1));
      checkVal("wb_2", 32'(bus.wb_2), 32'(e2));
      checkVal("wb_3", 32'(bus.wb_3), 32'(e3));
      checkVal("wb_4", 32'(bus.wb_4), 32'(e4));
      checkVal("row",  32'(bus.row),  32'(eRow));
      checkVal("col",  32'(bus.col),  32'(eCol));
      win = {bus.wb_1, bus.wb_2, bus.wb_3, bus.wb_4};
      if (bus.win_valid === 1'b1) begin
         winCount++;
         runWins.push_back(win);
         if (!haveFirst) begin
            firstWin  = win;
            haveFirst = 1;
         end
      end
      if (bus.frame_done === 1'b1) begin
         doneCount++;
         doneWin = win;
      end
   endtask

   // Reference: window phase follows the parity of its top-left pixel.
   task automatic modelStep(input bit valid, input bit clr, input logic [7:0] v);
      eValid = 1'b0;
      eDone  = 1'b0;
      if (clr) begin
         mr = 0;
         mc = 0;
      end else if (valid) begin
         img[mr][mc] = v;
         if (mr >= 1 && mc >= 1) begin
            eValid = 1'b1;
            e1   = img[mr-1][mc-1];
            e2   = img[mr-1][mc];
            e3   = img[mr][mc-1];
            e4   = v;
            eRow = ((mr - 1) % 2) == 0;
            eCol = ((mc - 1) % 2) == 1;
         end
         eDone = (mr == H-1) && (mc == W-1);
         mc++;
         if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
         end
      end
   endtask

   task automatic applyStimulus(input bit valid, input bit clr, input logic [7:0] v);
      @(negedge clk);
      bus.pix_valid = valid;
      bus.clear     = clr;
      bus.pix_in    = v;
      @(posedge clk);
      #1;
      modelStep(valid, clr, v);
      checkOutput();
   endtask

   task automatic startTally();
      winCount  = 0;
      doneCount = 0;
      haveFirst = 0;
      runWins.delete();
   endtask

   // Streams pixels in raster order; values are base+16*r+c or random, with optional idle gaps.
   task automatic streamPixels(input int count, input int base, input bit randVal, input int maxGap);
      logic [7:0] v;
      for (int i = 0; i < count; i++) begin
         v = randVal ? 8'($urandom) : 8'(base + 16 * (i / W) + (i % W));
         applyStimulus(1'b1, 1'b0, v);
         if (maxGap > 0) begin
            repeat ($urandom_range(maxGap, 1)) applyStimulus(1'b0, 1'b0, 8'($urandom));
         end
      end
   endtask

   task automatic checkFrame(input string tag, input logic [31:0] expFirst, input logic [31:0] expLast);
      checkVal({tag, "_win_count"},  32'(winCount),  32'((W-1) * (H-1)));
      checkVal({tag, "_done_count"}, 32'(doneCount), 32'd1);
      checkVal({tag, "_first_win"},  firstWin, expFirst);
      checkVal({tag, "_done_win"},   doneWin,  expLast);
   endtask

   task automatic compareToRef(input string tag);
      checkVal({tag, "_win_len"}, 32'(runWins.size()), 32'(refWins.size()));
      for (int i = 0; i < refWins.size() && i < runWins.size(); i++) begin
         checkVal({tag, "_win"}, runWins[i], refWins[i]);
      end
   endtask

   // Directed sequence of scenarios.
   initial begin
      $display("[TB] bayer_window_gen test start");
      bus.clear     = 1'b0;
      bus.pix_valid = 1'b0;
      bus.pix_in    = '0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = '0;

      // Reset state
      #12;
      checkOutput();
      @(negedge clk);
      n_rst = 1'b1;

      // Gapless frame, value 16r+c
      startTally();
      streamPixels(W * H, 0, 1'b0, 0);
      checkFrame("gapless", 32'h00011011, 32'h22233233);
      checkVal("gapless_win1", runWins[1], 32'h01021112);
      checkVal("gapless_win_2_1", runWins[3], 32'h10112021);
      checkVal("gapless_win_2_2", runWins[4], 32'h11122122);
      refWins = runWins;

      // Same stream with random 1-3 cycle gaps
      startTally();
      streamPixels(W * H, 0, 1'b0, 3);
      checkFrame("gapped", 32'h00011011, 32'h22233233);
      compareToRef("gapped");

      // Back-to-back frames, second one offset by 0x80
      startTally();
      streamPixels(W * H, 0, 1'b0, 0);
      startTally();
      streamPixels(W * H, 8'h80, 1'b0, 0);
      checkFrame("b2b", 32'h80819091, 32'ha2a3b2b3);

      // Random pixel values with random gaps
      startTally();
      streamPixels(W * H, 0, 1'b1, 3);
      checkVal("rand_win_count",  32'(winCount),  32'((W-1) * (H-1)));
      checkVal("rand_done_count", 32'(doneCount), 32'd1);

      // Reset asserted after accepting (2,2)
      startTally();
      streamPixels(2 * W + 3, 0, 1'b0, 0);
      @(negedge clk);
      bus.pix_valid = 1'b0;
      n_rst = 1'b0;
      #1;
      mr = 0; mc = 0;
      e1 = '0; e2 = '0; e3 = '0; e4 = '0;
      eRow = 1'b0; eCol = 1'b0; eValid = 1'b0; eDone = 1'b0;
      checkOutput();
      @(posedge clk);
      #1;
      checkOutput();
      @(negedge clk);
      n_rst = 1'b1;
      startTally();
      streamPixels(W * H, 8'h40, 1'b0, 0);
      checkFrame("post_reset", 32'h40415051, 32'h62637273);

      // clear together with a valid pixel at (1,3)
      startTally();
      streamPixels(W + 3, 0, 1'b0, 0);
      applyStimulus(1'b1, 1'b1, 8'h13);
      checkVal("clear_win_count", 32'(winCount), 32'd2);
      startTally();
      streamPixels(W * H, 0, 1'b0, 0);
      checkFrame("post_clear", 32'h00011011, 32'h22233233);
      compareToRef("post_clear");

      applyStimulus(1'b0, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
